// File: rtl/testframe_parser_ext.sv
// testframe_parser_ext
//
// Purpose: GMII receive-side test-frame parser. Validates the preamble/SFD,
// applies a per-octet data/mask filter over the first FILTER_LEN octets after
// the SFD, checks the CRC-32 residue and extracts the trailing test-frame
// fields (sequence number, seconds, nanoseconds). One result per frame is
// reported with a single-cycle o_frame_valid strobe; results hold until the
// next frame ends.
//
// Ports:
//   i_clk                     GMII rx clock
//   i_reset                   asynchronous, active-high reset
//   i_d / i_en / i_er         GMII rx data, data valid, error
//   i_testframe_filter_data   expected octets, octet k at [8k+7:8k]
//   i_testframe_filter_mask   per-bit compare enable, same layout
//   o_frame_valid             one-cycle result strobe
//   o_testframe_match         filter hit, length >= FILTER_LEN, no error
//   o_fcs_ok                  CRC residue correct (or checking disabled)
//   o_frame_error             bad preamble/SFD or er seen during the frame
//   o_frame_len               octets after SFD incl. FCS, saturating
//   o_sequence_num            64-bit big-endian field
//   o_timestamp_sec           48-bit big-endian field
//   o_timestamp_nsec          32-bit big-endian field

module testframe_parser_ext #(
    parameter int unsigned FILTER_LEN   = 40,
    parameter int unsigned PREAMBLE_MIN = 6,
    parameter int unsigned PREAMBLE_MAX = 7,
    parameter int unsigned TAIL_SKIP    = 4,
    parameter int unsigned FCS_CHECK    = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_d,
    input  logic                    i_en,
    input  logic                    i_er,
    input  logic [FILTER_LEN*8-1:0] i_testframe_filter_data,
    input  logic [FILTER_LEN*8-1:0] i_testframe_filter_mask,
    output logic                    o_frame_valid,
    output logic                    o_testframe_match,
    output logic                    o_fcs_ok,
    output logic                    o_frame_error,
    output logic [15:0]             o_frame_len,
    output logic [63:0]             o_sequence_num,
    output logic [47:0]             o_timestamp_sec,
    output logic [31:0]             o_timestamp_nsec
);

    // History holds seq(8) + sec(6) + nsec(4) + the skipped tail.
    localparam int unsigned HIST_LEN    = 18 + TAIL_SKIP;
    localparam int unsigned HIST_BITS   = HIST_LEN * 8;
    localparam int unsigned NSEC_LO     = 8 * TAIL_SKIP;
    localparam int unsigned SEC_LO      = NSEC_LO + 32;
    localparam int unsigned SEQ_LO      = SEC_LO + 48;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {StIdle, StPre, StData, StDrop} state_e;

    state_e               r_state;
    logic [7:0]           r_pcount;
    logic [15:0]          r_k;
    logic                 r_mismatch;
    logic                 r_err;
    logic [31:0]          r_crc;
    logic [HIST_BITS-1:0] r_hist;

    logic                 r_frame_valid;
    logic                 r_match;
    logic                 r_fcs_ok;
    logic                 r_frame_error;
    logic [15:0]          r_frame_len;
    logic [63:0]          r_seq;
    logic [47:0]          r_sec;
    logic [31:0]          r_nsec;

    logic [7:0]           w_fdata;
    logic [7:0]           w_fmask;
    logic                 w_in_filter;
    logic                 w_octet_miss;
    logic [31:0]          w_crc_rev;
    logic                 w_fcs_ok;
    logic                 w_match;

    // Reflected CRC-32 (poly 0x04C11DB7), one octet, LSB first.
    function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Select filter octet for the current index.
    always_comb begin
        w_fdata = '0;
        w_fmask = '0;
        for (int i = 0; i < int'(FILTER_LEN); i++) begin
            if (r_k == 16'(i)) begin
                w_fdata = i_testframe_filter_data[8*i +: 8];
                w_fmask = i_testframe_filter_mask[8*i +: 8];
            end
        end
    end

    assign w_in_filter  = (r_k < 16'(FILTER_LEN));
    assign w_octet_miss = |((i_d ^ w_fdata) & w_fmask);

    // The register runs reflected; the residue constant is in normal bit order.
    always_comb begin
        w_crc_rev = '0;
        for (int i = 0; i < 32; i++) begin
            w_crc_rev[i] = r_crc[31-i];
        end
    end

    assign w_fcs_ok = (FCS_CHECK == 0) || (w_crc_rev == CRC_RESIDUE);
    assign w_match  = !r_mismatch && (r_k >= 16'(FILTER_LEN)) && !r_err;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_pcount      <= '0;
            r_k           <= '0;
            r_mismatch    <= 1'b0;
            r_err         <= 1'b0;
            r_crc         <= 32'hFFFFFFFF;
            r_hist        <= '0;
            r_frame_valid <= 1'b0;
            r_match       <= 1'b0;
            r_fcs_ok      <= 1'b0;
            r_frame_error <= 1'b0;
            r_frame_len   <= '0;
            r_seq         <= '0;
            r_sec         <= '0;
            r_nsec        <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_en) begin
                        r_k        <= '0;
                        r_mismatch <= 1'b0;
                        r_err      <= 1'b0;
                        r_crc      <= 32'hFFFFFFFF;
                        r_hist     <= '0;
                        if (i_d == 8'h55) begin
                            r_state  <= StPre;
                            r_pcount <= 8'd1;
                        end else begin
                            r_state <= StDrop;
                        end
                    end
                end
                StPre: begin
                    if (!i_en) begin
                        r_state <= StIdle;
                    end else if (i_er) begin
                        r_state <= StDrop;
                    end else if (i_d == 8'hD5) begin
                        r_state <= (r_pcount < 8'(PREAMBLE_MIN)) ? StDrop : StData;
                    end else if (i_d == 8'h55) begin
                        if (r_pcount >= 8'(PREAMBLE_MAX)) begin
                            r_state <= StDrop;
                        end else begin
                            r_pcount <= r_pcount + 8'd1;
                        end
                    end else begin
                        r_state <= StDrop;
                    end
                end
                StData: begin
                    if (i_en) begin
                        r_hist <= {r_hist[HIST_BITS-9:0], i_d};
                        if (r_k != 16'hFFFF) begin
                            r_k <= r_k + 16'd1;
                        end
                        if (w_in_filter && w_octet_miss) begin
                            r_mismatch <= 1'b1;
                        end
                        r_crc <= crc32_step(r_crc, i_d);
                        if (i_er) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_state       <= StIdle;
                        r_frame_valid <= 1'b1;
                        r_match       <= w_match;
                        r_fcs_ok      <= w_fcs_ok;
                        r_frame_error <= r_err;
                        r_frame_len   <= r_k;
                        r_seq         <= r_hist[SEQ_LO +: 64];
                        r_sec         <= r_hist[SEC_LO +: 48];
                        r_nsec        <= r_hist[NSEC_LO +: 32];
                    end
                end
                StDrop: begin
                    if (!i_en) begin
                        r_state       <= StIdle;
                        r_frame_valid <= 1'b1;
                        r_match       <= 1'b0;
                        r_fcs_ok      <= 1'b0;
                        r_frame_error <= 1'b1;
                        r_frame_len   <= '0;
                        r_seq         <= '0;
                        r_sec         <= '0;
                        r_nsec        <= '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_frame_valid     = r_frame_valid;
    assign o_testframe_match = r_match;
    assign o_fcs_ok          = r_fcs_ok;
    assign o_frame_error     = r_frame_error;
    assign o_frame_len       = r_frame_len;
    assign o_sequence_num    = r_seq;
    assign o_timestamp_sec   = r_sec;
    assign o_timestamp_nsec  = r_nsec;

endmodule
